// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'h0040_0000;
  localparam int unsigned DEPTH_WORDS_DEF = 64;
  localparam int unsigned STARVE_MAX_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  // One past the last legal byte address; 33 bits so the top of the map cannot wrap.
  function automatic logic [WORD_W:0] addr_limit(input logic [WORD_W-1:0] base,
                                                 input int unsigned depth);
    return 33'(base) + (33'(depth) * 33'd4);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
interface mem_arb_if;
  import mem_arb_pkg::*;

  // fetch port
  logic              if_req;
  logic [WORD_W-1:0] if_addr;
  logic              if_ack;
  logic [WORD_W-1:0] if_rdata;
  logic              if_err;

  // load/store port
  logic              d_req;
  logic              d_we;
  logic [WORD_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic [WORD_W-1:0] d_rdata;
  logic              d_err;

  // memory array side
  logic [WORD_W-1:0] mem_dir;
  logic [WORD_W-1:0] mem_data_input;
  logic              mem_rd;
  logic              mem_wd;
  logic [WORD_W-1:0] mem_data_output;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_output,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_dir, mem_data_input, mem_rd, mem_wd
  );

  // requesters plus memory
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_output,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_dir, mem_data_input, mem_rd, mem_wd
  );

endinterface

// File: rtl/mem_arb_addr_chk.sv
// Combinational range and word-alignment check for one byte address.
module mem_arb_addr_chk
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic [WORD_W-1:0] addr,
  output logic              err_c
);

  localparam logic [WORD_W:0] LIMIT = addr_limit(BASE_ADDR, DEPTH_WORDS);

  logic below_c;
  logic above_c;
  logic misaligned_c;

  // Flag addresses outside [BASE_ADDR, LIMIT) or not on a word boundary.
  always_comb begin
    below_c      = addr < BASE_ADDR;
    above_c      = {1'b0, addr} >= LIMIT;
    misaligned_c = addr[1:0] != 2'b00;
    err_c        = below_c | above_c | misaligned_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter/sequencer for the unified instruction/data memory.
// One access every three cycles: IDLE (grant) -> ACCESS (strobe) -> RESP (ack).
// Data has priority over fetch. Define MEM_ARB_STARVE_LIMIT_EN to let a waiting
// fetch win once after STARVE_MAX consecutive data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.slave  bus
);

  arb_state_t        state;
  gnt_t              gnt;
  logic              we_q;
  logic              err_q;

  logic              pick_if_c;
  logic              sel_we_c;
  logic              addr_err_c;
  logic [WORD_W-1:0] sel_addr_c;
  logic [WORD_W-1:0] rd_word_c;

  // A zero starvation limit would let fetch pre-empt every data grant.
  if (STARVE_MAX == 0) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef MEM_ARB_STARVE_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 2);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit_c;

  // Fetch wins when it has watched STARVE_MAX data grants go by.
  assign starve_hit_c = starve_cnt == CNT_W'(STARVE_MAX);
  assign pick_if_c    = bus.if_req && (!bus.d_req || starve_hit_c);
`else
  // Strict data priority.
  assign pick_if_c    = bus.if_req && !bus.d_req;
`endif

  // Winner's request fields; fetch is always a read.
  assign sel_addr_c = pick_if_c ? bus.if_addr : bus.d_addr;
  assign sel_we_c   = !pick_if_c && bus.d_we;

  // Read data returned to the winner; stores and bad addresses return zero.
  assign rd_word_c  = (err_q || we_q) ? '0 : bus.mem_data_output;

  mem_arb_addr_chk #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_addr_chk (
    .addr  (sel_addr_c),
    .err_c (addr_err_c)
  );

  // Sequencer: grant in IDLE, strobe memory in ACCESS, ack in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      gnt                <= GNT_IF;
      we_q               <= 1'b0;
      err_q              <= 1'b0;
      bus.if_ack         <= 1'b0;
      bus.if_err         <= 1'b0;
      bus.if_rdata       <= '0;
      bus.d_ack          <= 1'b0;
      bus.d_err          <= 1'b0;
      bus.d_rdata        <= '0;
      bus.mem_dir        <= '0;
      bus.mem_data_input <= '0;
      bus.mem_rd         <= 1'b0;
      bus.mem_wd         <= 1'b0;
`ifdef MEM_ARB_STARVE_LIMIT_EN
      starve_cnt         <= '0;
`endif
    end else begin
      bus.mem_rd <= 1'b0;
      bus.mem_wd <= 1'b0;
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            gnt         <= pick_if_c ? GNT_IF : GNT_D;
            we_q        <= sel_we_c;
            err_q       <= addr_err_c;
            bus.mem_dir <= sel_addr_c;
            if (sel_we_c) begin
              bus.mem_data_input <= bus.d_wdata;
            end
            // Strobes are registered here so they are high exactly during ACCESS.
            bus.mem_rd  <= !addr_err_c && !sel_we_c;
            bus.mem_wd  <= !addr_err_c && sel_we_c;
`ifdef MEM_ARB_STARVE_LIMIT_EN
            if (pick_if_c) begin
              starve_cnt <= '0;
            end else if (bus.if_req) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
`endif
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          if (gnt == GNT_IF) begin
            bus.if_ack   <= 1'b1;
            bus.if_err   <= err_q;
            bus.if_rdata <= rd_word_c;
          end else begin
            bus.d_ack    <= 1'b1;
            bus.d_err    <= err_q;
            bus.d_rdata  <= rd_word_c;
          end
          state <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner
// sequences, and randomized traffic against a transaction-level memory model.
module tb_mem_arbiter;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned SMAX  = 4;
  localparam int          BOUND = 12;
  localparam int          NV    = 15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arb_if bus();

  mem_arbiter #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .STARVE_MAX  (SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory array the arbiter drives: combinational read, write on the clock edge.
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  assign bus.mem_data_output = mem[bus.mem_dir[7:2]];

  always @(posedge clk) begin
    if (bus.mem_wd === 1'b1) mem[bus.mem_dir[7:2]] <= bus.mem_data_input;
  end

  // Running count of strobe cycles.
  int rd_cnt = 0;
  int wd_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) rd_cnt++;
    if (bus.mem_wd === 1'b1) wd_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic addr_bad(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'(DEPTH * 4)) || (a[1:0] != 2'b00);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    err = addr_bad(a);
    rd  = 32'h0;
    if (!err) begin
      if (we) ref_mem[widx(a)] = wd;
      else    rd = ref_mem[widx(a)];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    logic [31:0] a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
    case (k)
      0:       return BASE - 32'd4;
      1:       return BASE + 32'(DEPTH * 4);
      2:       return a + 32'($urandom_range(1, 3));
      3:       return $urandom();
      default: return a;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    reset      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Raise the chosen requests in an IDLE cycle (cycle 0) and watch BOUND cycles.
  task automatic run_txn(input logic do_if, input logic [31:0] ia,
                         input logic do_d, input logic we, input logic [31:0] da,
                         input logic [31:0] wd,
                         output int i_cyc, output logic [31:0] i_rd, output logic i_err,
                         output int d_cyc, output logic [31:0] d_rd, output logic d_err,
                         output int i_acks, output int d_acks, output int rds, output int wds);
    int rd0 = rd_cnt;
    int wd0 = wd_cnt;
    i_cyc = -1; d_cyc = -1; i_rd = 32'h0; d_rd = 32'h0; i_err = 1'b0; d_err = 1'b0;
    i_acks = 0; d_acks = 0;
    bus.if_req = do_if; bus.if_addr = ia;
    bus.d_req = do_d; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd;
    for (int c = 1; c <= BOUND; c++) begin
      @(posedge clk); #1;
      if (bus.if_ack === 1'b1) begin
        i_acks++;
        if (i_cyc < 0) begin i_cyc = c; i_rd = bus.if_rdata; i_err = bus.if_err; end
        bus.if_req = 1'b0;
      end
      if (bus.d_ack === 1'b1) begin
        d_acks++;
        if (d_cyc < 0) begin d_cyc = c; d_rd = bus.d_rdata; d_err = bus.d_err; end
        bus.d_req = 1'b0;
      end
    end
    rds = rd_cnt - rd0;
    wds = wd_cnt - wd0;
  endtask

  task automatic txn_and_check(input string tag, input logic do_if, input logic [31:0] ia,
                               input logic do_d, input logic we, input logic [31:0] da,
                               input logic [31:0] wd,
                               input int e_icyc, input logic [31:0] e_ird, input logic e_ierr,
                               input int e_dcyc, input logic [31:0] e_drd, input logic e_derr,
                               input int e_rds, input int e_wds);
    int icyc, dcyc, iacks, dacks, rds, wds;
    logic [31:0] ird, drd;
    logic ierr, derr;
    run_txn(do_if, ia, do_d, we, da, wd, icyc, ird, ierr, dcyc, drd, derr, iacks, dacks, rds, wds);
    if (do_if) begin
      check({tag, "/if_cycle"}, 32'(icyc), 32'(e_icyc));
      check({tag, "/if_rdata"}, ird, e_ird);
      check({tag, "/if_err"}, 32'(ierr), 32'(e_ierr));
    end
    if (do_d) begin
      check({tag, "/d_cycle"}, 32'(dcyc), 32'(e_dcyc));
      check({tag, "/d_rdata"}, drd, e_drd);
      check({tag, "/d_err"}, 32'(derr), 32'(e_derr));
    end
    check({tag, "/if_acks"}, 32'(iacks), 32'(int'(do_if)));
    check({tag, "/d_acks"}, 32'(dacks), 32'(int'(do_d)));
    check({tag, "/rd_strobes"}, 32'(rds), 32'(e_rds));
    check({tag, "/wd_strobes"}, 32'(wds), 32'(e_wds));
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs [NV];

  // Hard stop if something wedges the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mrd, e_ird, e_drd, ia, da, wd;
    logic        merr, e_ierr, e_derr, do_if, do_d, we;
    int          e_icyc, e_dcyc, e_rds, e_wds, slot, mode;
    int          grants, if_pos, if_cyc;

    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    mem[1]  = 32'h8DEA_0050; ref_mem[1]  = 32'h8DEA_0050;
    mem[20] = 32'd18;        ref_mem[20] = 32'd18;

    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

    // ---- reset state ----
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst/if_ack", 32'(bus.if_ack), 32'h0);
    check("rst/d_ack", 32'(bus.d_ack), 32'h0);
    check("rst/if_err", 32'(bus.if_err), 32'h0);
    check("rst/d_err", 32'(bus.d_err), 32'h0);
    check("rst/if_rdata", bus.if_rdata, 32'h0);
    check("rst/d_rdata", bus.d_rdata, 32'h0);
    check("rst/mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rst/mem_wd", 32'(bus.mem_wd), 32'h0);
    check("rst/mem_dir", bus.mem_dir, 32'h0);
    check("rst/mem_data_input", bus.mem_data_input, 32'h0);
    reset = 1'b0;

    // ---- directed table ----
    vecs[0]  = '{1'b0, 1'b0, 32'h0040_0050, 32'h0,         32'd18,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0040_0058, 32'd25,        32'h0,         1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0040_0058, 32'h0,         32'd25,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h003F_FFFC, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0040_0100, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0040_0002, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0040_0100, 32'h55,        32'h0,         1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h003F_FFFC, 32'h66,        32'h0,         1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0040_00FC, 32'h0,         32'hA000_003F, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,         32'hA000_0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h0040_00FC, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0040_00FC, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,         32'h8DEA_0050, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0040_0004, 32'h0,         32'h8DEA_0050, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0040_0003, 32'h0,         32'h0,         1'b1};

    for (int i = 0; i < NV; i++) begin
      e_rds = (!vecs[i].err && !vecs[i].we) ? 1 : 0;
      e_wds = (!vecs[i].err &&  vecs[i].we) ? 1 : 0;
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, mrd, merr);
      if (vecs[i].is_if)
        txn_and_check($sformatf("vec%0d", i), 1'b1, vecs[i].addr, 1'b0, 1'b0, 32'h0, 32'h0,
                      2, vecs[i].rd, vecs[i].err, 0, 32'h0, 1'b0, e_rds, e_wds);
      else
        txn_and_check($sformatf("vec%0d", i), 1'b0, 32'h0, 1'b1, vecs[i].we, vecs[i].addr,
                      vecs[i].wdata, 0, 32'h0, 1'b0, 2, vecs[i].rd, vecs[i].err, e_rds, e_wds);
      check($sformatf("vec%0d/mem_dir_hold", i), bus.mem_dir, vecs[i].addr);
    end

    // ---- contention: data acks at cycle 2, fetch at cycle 5 ----
    txn_and_check("contention", 1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h0040_0050, 32'h0,
                  5, 32'h8DEA_0050, 1'b0, 2, 32'd18, 1'b0, 2, 0);

    // ---- reset while a store is in ACCESS: the write lands, the ack is lost ----
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0040_0078; bus.d_wdata = 32'h77;
    @(posedge clk); #1;
    check("rst_acc/mem_wd_in_access", 32'(bus.mem_wd), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_acc/d_ack", 32'(bus.d_ack), 32'h0);
    check("rst_acc/mem_wd", 32'(bus.mem_wd), 32'h0);
    check("rst_acc/mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rst_acc/mem_dir", bus.mem_dir, 32'h0);
    check("rst_acc/mem_data_input", bus.mem_data_input, 32'h0);
    check("rst_acc/d_rdata", bus.d_rdata, 32'h0);
    check("rst_acc/if_rdata", bus.if_rdata, 32'h0);
    bus.d_req = 1'b0;
    reset = 1'b0;
    model_access(1'b1, 32'h0040_0078, 32'h77, mrd, merr);
    @(posedge clk); #1;
    check("rst_acc/d_ack_after", 32'(bus.d_ack), 32'h0);
    txn_and_check("rst_acc/readback", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0078, 32'h0,
                  0, 32'h0, 1'b0, 2, 32'h77, 1'b0, 1, 0);
    model_access(1'b1, 32'h0040_0078, 32'h78, mrd, merr);
    txn_and_check("rst_acc/reissue", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0078, 32'h78,
                  0, 32'h0, 1'b0, 2, 32'h0, 1'b0, 0, 1);
    txn_and_check("rst_acc/reread", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0078, 32'h0,
                  0, 32'h0, 1'b0, 2, 32'h78, 1'b0, 1, 0);

    // ---- starvation: data held high continuously, fetch waiting ----
    grants = 0; if_pos = -1; if_cyc = -1; mrd = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = BASE + 32'd8;
    bus.if_req = 1'b1; bus.if_addr = BASE + 32'd12;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack === 1'b1) grants++;
      if (bus.if_ack === 1'b1) begin
        grants++;
        if (if_pos < 0) begin if_pos = grants; if_cyc = c; mrd = bus.if_rdata; end
        bus.if_req = 1'b0;
      end
    end
`ifdef MEM_ARB_STARVE_LIMIT_EN
    check("starve/fetch_grant_index", 32'(if_pos), 32'(SMAX + 1));
    check("starve/fetch_ack_cycle", 32'(if_cyc), 32'd14);
    check("starve/fetch_rdata", mrd, ref_mem[3]);
    check("starve/total_grants", 32'(grants), 32'd10);
`else
    check("strict/fetch_never_acked", 32'(if_pos), 32'hFFFF_FFFF);
    check("strict/data_grants", 32'(grants), 32'd10);
    bus.d_req = 1'b0;
    for (int c = 1; c <= BOUND; c++) begin
      @(posedge clk); #1;
      if (bus.if_ack === 1'b1 && if_cyc < 0) begin
        if_cyc = c; mrd = bus.if_rdata; bus.if_req = 1'b0;
      end
    end
    check("strict/fetch_after_release", 32'(if_cyc > 0), 32'h1);
    check("strict/fetch_rdata", mrd, ref_mem[3]);
`endif
    do_reset();

    // ---- randomized traffic against the model ----
    // Each trial lets every raised request finish, so no data-grant streak
    // carries from one trial to the next: data simply goes first when both ask.
    for (int t = 0; t < 200; t++) begin
      mode  = int'($urandom_range(0, 2));
      do_if = (mode != 0);
      do_d  = (mode != 1);
      ia    = rand_addr();
      da    = rand_addr();
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom();
      e_rds = 0; e_wds = 0; e_icyc = 0; e_dcyc = 0;
      e_ird = 32'h0; e_drd = 32'h0; e_ierr = 1'b0; e_derr = 1'b0;
      slot  = 2;
      if (do_d) begin
        model_access(we, da, wd, e_drd, e_derr);
        e_dcyc = slot;
        slot   = slot + 3;
        if (!e_derr) begin
          if (we) e_wds++;
          else    e_rds++;
        end
      end
      if (do_if) begin
        model_access(1'b0, ia, 32'h0, e_ird, e_ierr);
        e_icyc = slot;
        if (!e_ierr) e_rds++;
      end
      txn_and_check($sformatf("rnd%0d", t), do_if, ia, do_d, we, da, wd,
                    e_icyc, e_ird, e_ierr, e_dcyc, e_drd, e_derr, e_rds, e_wds);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
